cnn_layer_accel_job_ctrl: RTL and testbench



---
 rtl/cnn_layer_accel_job_ctrl_pkg.sv | 7 +
 rtl/cnn_layer_accel_pix_skid.sv | 35 +++
 rtl/cnn_layer_accel_job_ctrl.sv | 117 +++++++++++
 tb/tb_cnn_layer_accel_job_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_job_ctrl_pkg.sv
// cnn_layer_accel_job_ctrl_pkg: job controller FSM states and pixel channel layout
package cnn_layer_accel_job_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT_FETCH, STREAM, WAIT_COMPLETE} state_t;
  localparam int CH_W = 16;
  localparam int NUM_CH = 8;
  localparam int PIX_W = CH_W * NUM_CH;
endpackage

// File: rtl/cnn_layer_accel_pix_skid.sv
// cnn_layer_accel_pix_skid: 2-entry FIFO absorbing the buffer read latency against pixel backpressure
module cnn_layer_accel_pix_skid
  import cnn_layer_accel_job_ctrl_pkg::*;
#(
  parameter int W = PIX_W
) (
  input  logic         clk_if,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr, pop;
  assign pop = valid && ready;
  assign valid = count != 2'd0;
  assign data = valid ? mem[rd_ptr] : '0;
  // the controller never loads a full FIFO, so load needs no guard here
  always_ff @(posedge clk_if) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (load) mem[wr_ptr] <= load_data;
      wr_ptr <= wr_ptr ^ load;
      rd_ptr <= rd_ptr ^ pop;
      count <= count + {1'b0, load} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// cnn_layer_accel_job_ctrl: sequences one quad job and streams its rows from the pixel buffer.
// Define JOB_CTRL_WATCHDOG_EN to add a stall watchdog that aborts to IDLE with err set.
module cnn_layer_accel_job_ctrl
  import cnn_layer_accel_job_ctrl_pkg::*;
#(
  parameter int C_PIXEL_BUS_WIDTH = PIX_W,
  parameter int C_ADDR_WIDTH = 16,
  parameter int C_DIM_WIDTH = 10,
  parameter int C_TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk_if,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [C_DIM_WIDTH-1:0]       cmd_num_rows,
  input  logic [C_DIM_WIDTH-1:0]       cmd_num_cols,
  input  logic [C_ADDR_WIDTH-1:0]      cmd_base_addr,
  output logic                         mem_rd_en,
  output logic [C_ADDR_WIDTH-1:0]      mem_rd_addr,
  input  logic [C_PIXEL_BUS_WIDTH-1:0] mem_rd_data,
  output logic                         job_start,
  input  logic                         job_accept,
  input  logic                         job_fetch_request,
  output logic                         job_fetch_ack,
  output logic                         job_fetch_complete,
  input  logic                         job_complete,
  output logic                         job_complete_ack,
  output logic                         pixel_valid,
  input  logic                         pixel_ready,
  output logic [C_PIXEL_BUS_WIDTH-1:0] pixel_data,
  output logic                         busy,
  output logic                         job_done,
  output logic                         err
);
  state_t state, next;
  logic [C_DIM_WIDTH-1:0] rows, cols, row_cnt, rd_cnt, beat_cnt;
  logic [C_ADDR_WIDTH-1:0] addr;
  logic [1:0] skid_cnt;
  logic [2:0] occ;
  logic rd_q, xfer, last, accept, early_cmp, abort, row_end, wd_hit;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign job_start = state == START;
  assign accept = cmd_valid && state == IDLE;
  assign xfer = pixel_valid && pixel_ready;
  assign last = xfer && beat_cnt == cols - 1'b1;
  assign early_cmp = job_complete && (state == START || state == WAIT_FETCH || state == STREAM);
  assign abort = early_cmp || wd_hit;
  assign row_end = state == STREAM && last && !abort;
  // occupancy counts the beat leaving this cycle so reads keep pace at one beat per cycle
  assign occ = {1'b0, skid_cnt} + {2'b0, rd_q} - {2'b0, xfer};
  assign mem_rd_en = state == STREAM && !abort && rd_cnt != cols && occ < 3'd2;
  assign mem_rd_addr = addr;
  cnn_layer_accel_pix_skid #(.W(C_PIXEL_BUS_WIDTH)) u_skid (
    .clk_if,
    .rst,
    .flush(abort),
    .load(rd_q),
    .load_data(mem_rd_data),
    .valid(pixel_valid),
    .ready(pixel_ready),
    .data(pixel_data),
    .count(skid_cnt)
  );
`ifdef JOB_CTRL_WATCHDOG_EN
  logic [31:0] wd_cnt;
  always_ff @(posedge clk_if) begin
    if (rst || state == IDLE || next != state || xfer) wd_cnt <= '0;
    else wd_cnt <= wd_cnt + 1;
  end
  assign wd_hit = state != IDLE && wd_cnt == C_TIMEOUT_CYCLES;
`else
  assign wd_hit = 1'b0;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:          next = cmd_valid ? START : IDLE;
      START:         next = job_accept ? WAIT_FETCH : START;
      WAIT_FETCH:    next = job_fetch_request ? STREAM : WAIT_FETCH;
      STREAM:        next = last ? (row_cnt + 1'b1 < rows ? WAIT_FETCH : WAIT_COMPLETE) : STREAM;
      WAIT_COMPLETE: next = job_complete_ack ? IDLE : WAIT_COMPLETE;
      default:       next = IDLE;
    endcase
    if (early_cmp) next = WAIT_COMPLETE;
    if (wd_hit) next = IDLE;
  end
  always_ff @(posedge clk_if) begin
    if (rst) begin
      state <= IDLE;
      {rows, cols, row_cnt, rd_cnt, beat_cnt} <= '0;
      addr <= '0;
      {rd_q, job_fetch_ack, job_fetch_complete, job_complete_ack, job_done, err} <= '0;
    end else begin
      state <= next;
      rd_q <= mem_rd_en;
      job_fetch_ack <= state == WAIT_FETCH && job_fetch_request && !abort;
      job_fetch_complete <= row_end;
      job_complete_ack <= !wd_hit && (early_cmp || (state == WAIT_COMPLETE && job_complete && !job_complete_ack));
      job_done <= state == WAIT_COMPLETE && job_complete_ack && !wd_hit;
      err <= !accept && (err || abort || (state == WAIT_COMPLETE && job_fetch_request));
      if (accept) begin
        rows <= cmd_num_rows;
        cols <= cmd_num_cols;
        row_cnt <= '0;
        addr <= cmd_base_addr;
      end
      if (mem_rd_en) begin
        addr <= addr + 1'b1;
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (xfer) beat_cnt <= beat_cnt + 1'b1;
      if (state == WAIT_FETCH) {rd_cnt, beat_cnt} <= '0;
      if (row_end) row_cnt <= row_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// tb_cnn_layer_accel_job_ctrl: quad/buffer model driving random jobs against expected address and beat streams
module tb_cnn_layer_accel_job_ctrl;
  import cnn_layer_accel_job_ctrl_pkg::*;
  logic clk_if = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [9:0] cmd_num_rows = '0, cmd_num_cols = '0;
  logic [15:0] cmd_base_addr = '0, mem_rd_addr;
  logic mem_rd_en;
  logic [127:0] mem_rd_data = '0, pixel_data;
  logic job_start, job_accept = 1'b0, job_fetch_request = 1'b0, job_fetch_ack, job_fetch_complete;
  logic job_complete = 1'b0, job_complete_ack, pixel_valid, pixel_ready = 1'b0, busy, job_done, err;
  int n_tests = 0, n_fail = 0;
  logic [15:0] exp_addr = '0, job_base = '0;
  int rd_count = 0, beat_k = 0, fc_cnt = 0, job_cols = 0;

  always #5 clk_if = ~clk_if;

  cnn_layer_accel_job_ctrl dut (
    .clk_if(clk_if), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_rows(cmd_num_rows),
    .cmd_num_cols(cmd_num_cols), .cmd_base_addr(cmd_base_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .job_start(job_start), .job_accept(job_accept), .job_fetch_request(job_fetch_request),
    .job_fetch_ack(job_fetch_ack), .job_fetch_complete(job_fetch_complete),
    .job_complete(job_complete), .job_complete_ack(job_complete_ack),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data),
    .busy(busy), .job_done(job_done), .err(err)
  );

  function automatic logic [127:0] pix(input logic [15:0] a);
    logic [127:0] d;
    for (int c = 0; c < NUM_CH; c++) d[c*CH_W +: CH_W] = 16'(a + c * 'h1357);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // pixel buffer with one cycle read latency
  always @(posedge clk_if) if (mem_rd_en) mem_rd_data <= pix(mem_rd_addr);

  always @(negedge clk_if)
    if (!rst && mem_rd_en) begin
      chk("rd_addr", mem_rd_addr, exp_addr);
      exp_addr++;
      rd_count++;
    end

  task automatic chk_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_outs", {busy, job_done, err, job_start, job_fetch_ack, job_fetch_complete,
                     job_complete_ack, pixel_valid, mem_rd_en}, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_data", pixel_data, 0);
  endtask

  task automatic start_job(input int rows, input int cols, input logic [15:0] base, input int dly);
    @(negedge clk_if);
    chk("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_num_rows = 10'(rows);
    cmd_num_cols = 10'(cols);
    cmd_base_addr = base;
    exp_addr = base;
    job_base = base;
    job_cols = cols;
    rd_count = 0;
    beat_k = 0;
    fc_cnt = 0;
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk_if);
      cmd_num_rows = 10'($urandom_range(1, 9));
      cmd_num_cols = 10'($urandom_range(1, 9));
      cmd_base_addr = 16'($urandom);
      chk("start_hi", job_start, 1);
      chk("no_ack_pre", job_fetch_ack, 0);
      chk("busy_ready", {busy, cmd_ready}, 2'b10);
      chk("err_clr", err, 0);
      if (i == dly) job_accept = 1'b1;
    end
    @(negedge clk_if);
    job_accept = 1'b0;
    cmd_valid = 1'b0;
    chk("start_lo", job_start, 0);
  endtask

  task automatic fetch_row(input int mode);
    bit got_ack, stalled;
    logic [127:0] prev;
    int beats;
    got_ack = 0;
    stalled = 0;
    beats = 0;
    prev = '0;
    job_fetch_request = 1'b1;
    for (int t = 0; t < 8 && !got_ack; t++) begin
      @(negedge clk_if);
      got_ack = job_fetch_ack;
    end
    job_fetch_request = 1'b0;
    if (!got_ack) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    for (int t = 1; t <= 4 * job_cols + 20; t++) begin
      @(negedge clk_if);
      if (t == 1) chk("ack_pulse", job_fetch_ack, 0);
      if (stalled) chk("stall_hold", pixel_data, prev);
      if (job_fetch_complete) begin
        chk("row_beats", beats, job_cols);
        chk("fc_valid", pixel_valid, 0);
        fc_cnt++;
        return;
      end
      pixel_ready = mode == 0 ? 1'b1 : mode == 1 ? (t % 4 == 1 || t % 4 == 0) : 1'($urandom_range(0, 1));
      if (pixel_valid && pixel_ready) begin
        if (mode == 0 && beats == 0) chk("first_beat_lat", t, 2);
        chk("beat_data", pixel_data, pix(16'(job_base + beat_k)));
        beat_k++;
        beats++;
      end
      stalled = pixel_valid && !pixel_ready;
      prev = pixel_data;
    end
    chk("fc_timeout", 0, 1);
  endtask

  task automatic finish_job(input bit exp_err, input bit bad_req, input int rows_fetched);
    bit got;
    got = 0;
    if (bad_req) begin
      job_fetch_request = 1'b1;
      @(negedge clk_if);
      job_fetch_request = 1'b0;
      chk("bad_req_err", err, 1);
      chk("bad_req_no_ack", job_fetch_ack, 0);
    end
    job_complete = 1'b1;
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clk_if);
      got = job_complete_ack;
    end
    job_complete = 1'b0;
    if (!got) begin
      chk("cack_timeout", 0, 1);
      return;
    end
    chk("cack_err", err, exp_err);
    chk("cack_busy", busy, 1);
    @(negedge clk_if);
    chk("done", job_done, 1);
    chk("cack_pulse", job_complete_ack, 0);
    chk("done_idle", cmd_ready, 1);
    @(negedge clk_if);
    chk("done_pulse", job_done, 0);
    chk("idle_busy", busy, 0);
    chk("fc_cnt", fc_cnt, rows_fetched);
    chk("rd_cnt", rd_count, rows_fetched * job_cols);
  endtask

  task automatic run_job(input int rows, input int cols, input logic [15:0] base, input int dly,
                         input int mode, input int early, input bit bad_req);
    int n;
    n = early >= 0 ? early : rows;
    start_job(rows, cols, base, dly);
    for (int r = 0; r < n; r++) fetch_row(mode);
    finish_job(early >= 0 || bad_req, bad_req, n);
  endtask

  initial begin
    repeat (3) @(negedge clk_if);
    chk_reset();
    rst = 1'b0;
    run_job(10, 10, 16'h0000, 0, 0, -1, 0);
    run_job(1, 4, 16'h0100, 0, 1, -1, 0);
    run_job(2, 3, 16'h0200, 7, 0, -1, 0);
    run_job(1, 4, 16'hFFFE, 0, 0, -1, 0);
    run_job(5, 2, 16'h0300, 0, 2, 3, 0);
    run_job(2, 2, 16'h0400, 1, 2, -1, 1);
    start_job(3, 6, 16'h0500, 0);
    pixel_ready = 1'b1;
    job_fetch_request = 1'b1;
    @(negedge clk_if);
    job_fetch_request = 1'b0;
    repeat (3) @(negedge clk_if);
    rst = 1'b1;
    @(negedge clk_if);
    chk_reset();
    rst = 1'b0;
    run_job(2, 2, 16'h0600, 0, 0, -1, 0);
    run_job(1, 1, 16'h0700, 0, 0, -1, 0);
    repeat (8) run_job($urandom_range(1, 4), $urandom_range(1, 6), 16'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 2), -1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
